// File: rtl/poly_compress_pack_if.sv
// Handshake bundle for poly_compress_pack: start/busy/done control, coefficient RAM
// read port and the packed byte stream.
interface poly_compress_pack_if #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned data_Width = 12
) ();
    logic                  enable;
    logic [data_Width-1:0] Coeff_RData;
    logic [ADDR_W-1:0]     Coeff_RAd;
    logic                  busy;
    logic [7:0]            oByte;
    logic                  oByte_valid;
    logic                  oByte_ready;
    logic                  Function_done;

    // The packer itself
    modport slave (
        input  enable, Coeff_RData, oByte_ready,
        output Coeff_RAd, busy, oByte, oByte_valid, Function_done
    );

    // Controller / RAM / byte consumer side
    modport master (
        output enable, Coeff_RData, oByte_ready,
        input  Coeff_RAd, busy, oByte, oByte_valid, Function_done
    );
endinterface

// File: rtl/poly_compress_pack.sv
// Serial Kyber Compress_q(x, COMP_D) over a polynomial held in a synchronous RAM,
// packing the COMP_D-bit results little-endian into a valid/ready byte stream.
module poly_compress_pack #(
    parameter int unsigned KYBER_N    = 256,
    parameter int unsigned KYBER_Q    = 3329,
    parameter int unsigned data_Width = 12,
    parameter int unsigned COMP_D     = 1,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    poly_compress_pack_if.slave bus
);

    localparam int unsigned ACC_W  = COMP_D + 7;
    localparam int unsigned CNT_W  = $clog2(ACC_W + 1);
    localparam int unsigned NUM_W  = data_Width + COMP_D + 1;
    localparam int unsigned HALF_Q = KYBER_Q / 2;
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(KYBER_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_COMP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state,  state_n;
    logic [ADDR_W-1:0]   addr,   addr_n;
    logic                busy,   busy_n;
    logic [7:0]          obyte,  obyte_n;
    logic                ovalid, ovalid_n;
    logic                done,   done_n;
    logic [ACC_W-1:0]    acc,    acc_n;
    logic [CNT_W-1:0]    cnt,    cnt_n;
    logic [COMP_D-1:0]   t_q,    t_n;

    logic [ACC_W-1:0]    acc_add, acc_sh;
    logic [CNT_W-1:0]    cnt_add, cnt_sh;

    // Rounded x*2^d/q; the divisor is a constant so this maps to fixed logic
    function automatic logic [COMP_D-1:0] compress(input logic [data_Width-1:0] x);
        logic [NUM_W-1:0] num;
        num = (NUM_W'(x) << COMP_D) + NUM_W'(HALF_Q);
        return COMP_D'(num / NUM_W'(KYBER_Q));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr   <= '0;
            busy   <= 1'b0;
            obyte  <= '0;
            ovalid <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            t_q    <= '0;
        end else begin
            state  <= state_n;
            addr   <= addr_n;
            busy   <= busy_n;
            obyte  <= obyte_n;
            ovalid <= ovalid_n;
            done   <= done_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            t_q    <= t_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr;
        busy_n   = busy;
        obyte_n  = obyte;
        ovalid_n = ovalid;
        done_n   = 1'b0;
        acc_n    = acc;
        cnt_n    = cnt;
        t_n      = t_q;

        // New coefficient lands above the bits still waiting; bytes leave from the bottom
        acc_add = acc | (ACC_W'(t_q) << cnt);
        cnt_add = cnt + CNT_W'(COMP_D);
        acc_sh  = acc >> 8;
        cnt_sh  = cnt - CNT_W'(8);

        case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    state_n = S_READ;
                    addr_n  = '0;
                    busy_n  = 1'b1;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_READ: state_n = S_WAIT;
            S_WAIT: begin
                t_n     = compress(bus.Coeff_RData);
                state_n = S_COMP;
            end
            S_COMP: begin
                acc_n = acc_add;
                cnt_n = cnt_add;
                if (cnt_add >= CNT_W'(8)) begin
                    state_n  = S_EMIT;
                    obyte_n  = acc_add[7:0];
                    ovalid_n = 1'b1;
                end else if (addr == LAST_K) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_READ;
                    addr_n  = addr + ADDR_W'(1);
                end
            end
            S_EMIT: begin
                if (bus.oByte_ready) begin
                    acc_n = acc_sh;
                    cnt_n = cnt_sh;
                    if (cnt_sh >= CNT_W'(8)) begin
                        obyte_n = acc_sh[7:0];
                    end else begin
                        ovalid_n = 1'b0;
                        if (addr == LAST_K) begin
                            state_n = S_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_READ;
                            addr_n  = addr + ADDR_W'(1);
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.Coeff_RAd     = addr;
    assign bus.busy          = busy;
    assign bus.oByte         = obyte;
    assign bus.oByte_valid   = ovalid;
    assign bus.Function_done = done;

endmodule

// File: tb/tb_poly_compress_pack.sv
// Directed bench for poly_compress_pack: three instances (COMP_D = 1, 4, 10) share one
// coefficient memory image; one instance is exercised at a time.
module tb_poly_compress_pack;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       ready = 1'b0;
    logic [2:0] en    = '0;
    int         sel   = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    poly_compress_pack_if #(.ADDR_W(8), .data_Width(12)) b1 ();
    poly_compress_pack_if #(.ADDR_W(8), .data_Width(12)) b4 ();
    poly_compress_pack_if #(.ADDR_W(8), .data_Width(12)) b10 ();

    poly_compress_pack #(.KYBER_N(256), .KYBER_Q(3329), .data_Width(12), .COMP_D(1), .ADDR_W(8))
        u_d1 (.clk(clk), .rst(rst), .bus(b1));
    poly_compress_pack #(.KYBER_N(256), .KYBER_Q(3329), .data_Width(12), .COMP_D(4), .ADDR_W(8))
        u_d4 (.clk(clk), .rst(rst), .bus(b4));
    poly_compress_pack #(.KYBER_N(256), .KYBER_Q(3329), .data_Width(12), .COMP_D(10), .ADDR_W(8))
        u_d10 (.clk(clk), .rst(rst), .bus(b10));

    logic [11:0] mem [256];

    // Synchronous-read RAM model, one read port per instance
    always @(posedge clk) begin
        b1.Coeff_RData  <= mem[b1.Coeff_RAd];
        b4.Coeff_RData  <= mem[b4.Coeff_RAd];
        b10.Coeff_RData <= mem[b10.Coeff_RAd];
    end

    assign b1.enable       = en[0];
    assign b4.enable       = en[1];
    assign b10.enable      = en[2];
    assign b1.oByte_ready  = ready;
    assign b4.oByte_ready  = ready;
    assign b10.oByte_ready = ready;

    logic       cv, cdone, cbusy;
    logic [7:0] cb;
    always_comb begin
        cv = b1.oByte_valid; cb = b1.oByte; cdone = b1.Function_done; cbusy = b1.busy;
        if (sel == 1) begin
            cv = b4.oByte_valid; cb = b4.oByte; cdone = b4.Function_done; cbusy = b4.busy;
        end else if (sel == 2) begin
            cv = b10.oByte_valid; cb = b10.oByte; cdone = b10.Function_done; cbusy = b10.busy;
        end
    end

    logic [7:0] cap  [$];
    logic [7:0] expq [$];

    function automatic int compress_ref(input int x, input int d);
        return (((x << d) + 3329 / 2) / 3329) % (1 << d);
    endfunction

    // Bit-level reference: stream bit b is bit (b mod d) of coefficient b/d
    task automatic build_expected(input int d);
        int nbytes;
        logic [7:0] by;
        int t;
        int b;
        nbytes = 256 * d / 8;
        expq.delete();
        for (int j = 0; j < nbytes; j++) begin
            by = '0;
            for (int i = 0; i < 8; i++) begin
                b = j * 8 + i;
                t = compress_ref(int'(mem[b / d]), d);
                by[i] = t[b % d];
            end
            expq.push_back(by);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (cap.size() < expq.size()) ? cap.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (cap[i] !== expq[i]) return i;
        return -1;
    endfunction

    // Start instance s and collect its byte stream until Function_done. The cycle count
    // includes the cycle presenting enable and the Function_done cycle; -1 on timeout.
    task automatic run_dut(input int s, input bit rnd, input int poke_at, input int max_cyc,
                           output int cycles, output int stall_bad);
        logic       pv, pr;
        logic [7:0] pb;
        bit         seen;
        cap.delete();
        sel = s; cycles = 0; stall_bad = 0; seen = 0; pv = 1'b0; pr = 1'b1; pb = '0;
        @(negedge clk);
        en[s] = 1'b1;
        ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        cycles = 1;
        while (!seen && cycles < max_cyc) begin
            @(negedge clk);
            cycles++;
            en = '0;
            if (cycles == poke_at) en[s] = 1'b1;
            if (pv && !pr && (!cv || cb !== pb)) stall_bad++;
            if (cdone) begin
                seen = 1;
            end else begin
                ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
                if (cv && ready) cap.push_back(cb);
                pv = cv; pr = ready; pb = cb;
            end
        end
        en = '0;
        if (!seen) cycles = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (b1.Coeff_RAd !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", b1.Coeff_RAd); end
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b1.busy); end
        checks++; if (b1.oByte !== 8'h00) begin errors++; $display("FAIL reset_obyte got %h exp 00", b1.oByte); end
        checks++; if (b10.oByte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", b10.oByte_valid); end
        checks++; if (b4.Function_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", b4.Function_done); end
        rst = 1'b0;
    endtask

    task automatic test_d1_const();
        int         xs [7] = '{1665, 0, 832, 833, 2496, 2497, 3328};
        logic [7:0] ex [7] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        int cyc, sb, bad;
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 256; k++) mem[k] = 12'(xs[v]);
            run_dut(0, 1'b0, 0, 2000, cyc, sb);
            checks++; if (cyc !== 802) begin errors++; $display("FAIL d1_len x=%0d got %0d cycles exp 802", xs[v], cyc); end
            checks++; if (cbusy !== 1'b0) begin errors++; $display("FAIL d1_busy_at_done x=%0d got %b exp 0", xs[v], cbusy); end
            checks++; if (cap.size() !== 32) begin errors++; $display("FAIL d1_count x=%0d got %0d exp 32", xs[v], cap.size()); end
            bad = 0;
            foreach (cap[i]) if (cap[i] !== ex[v]) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL d1_bytes x=%0d got %0d wrong exp all %h", xs[v], bad, ex[v]); end
            @(negedge clk);
            checks++; if (cdone !== 1'b0) begin errors++; $display("FAIL d1_done_pulse x=%0d got %b exp 0", xs[v], cdone); end
        end
    endtask

    task automatic test_d1_alternating();
        int cyc, sb, bad;
        for (int k = 0; k < 256; k++) mem[k] = (k % 2 == 0) ? 12'd833 : 12'd832;
        run_dut(0, 1'b0, 0, 2000, cyc, sb);
        checks++; if (cap.size() !== 32) begin errors++; $display("FAIL alt_count got %0d exp 32", cap.size()); end
        bad = 0;
        foreach (cap[i]) if (cap[i] !== 8'h55) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL alt_bytes got %0d wrong exp all 55", bad); end
    endtask

    task automatic test_d4();
        int cyc, sb, bad, fd;
        for (int k = 0; k < 256; k++) mem[k] = 12'd1665;
        run_dut(1, 1'b0, 0, 3000, cyc, sb);
        checks++; if (cyc !== 898) begin errors++; $display("FAIL d4_len got %0d exp 898", cyc); end
        checks++; if (cap.size() !== 128) begin errors++; $display("FAIL d4_count got %0d exp 128", cap.size()); end
        bad = 0;
        foreach (cap[i]) if (cap[i] !== 8'h88) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL d4_const got %0d wrong exp all 88", bad); end

        for (int k = 0; k < 256; k++) mem[k] = 12'(k);
        build_expected(4);
        run_dut(1, 1'b0, 0, 3000, cyc, sb);
        checks++; if (cap.size() !== 128) begin errors++; $display("FAIL d4_ramp_count got %0d exp 128", cap.size()); end
        fd = first_diff();
        checks++; if (fd !== -1) begin errors++; $display("FAIL d4_ramp byte %0d got %h exp %h", fd, cap[fd], expq[fd]); end
        checks++; if (cap.size() == 128 && cap[127] !== 8'h11) begin errors++; $display("FAIL d4_ramp_last got %h exp 11", cap[127]); end
    endtask

    task automatic test_d10();
        int cyc, sb, bad, fd;
        for (int k = 0; k < 256; k++) mem[k] = 12'd3328;
        run_dut(2, 1'b0, 0, 4000, cyc, sb);
        checks++; if (cyc !== 1090) begin errors++; $display("FAIL d10_len got %0d exp 1090", cyc); end
        checks++; if (cap.size() !== 320) begin errors++; $display("FAIL d10_count got %0d exp 320", cap.size()); end
        bad = 0;
        foreach (cap[i]) if (cap[i] !== 8'h00) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL d10_wrap got %0d wrong exp all 00", bad); end

        for (int k = 0; k < 256; k++) mem[k] = 12'(13 * k);
        build_expected(10);
        run_dut(2, 1'b0, 0, 4000, cyc, sb);
        checks++; if (cap.size() !== 320) begin errors++; $display("FAIL d10_ramp_count got %0d exp 320", cap.size()); end
        fd = first_diff();
        checks++; if (fd !== -1) begin errors++; $display("FAIL d10_ramp byte %0d got %h exp %h", fd, cap[fd], expq[fd]); end
        checks++; if (cap.size() > 1 && cap[1] !== 8'h10) begin errors++; $display("FAIL d10_straddle got %h exp 10", cap[1]); end
    endtask

    task automatic test_back_to_back_stall();
        int cyc, sb, fd;
        for (int k = 0; k < 256; k++) mem[k] = 12'(13 * k);
        build_expected(10);
        run_dut(2, 1'b1, 0, 8000, cyc, sb);
        ready = 1'b1;
        checks++; if (cyc < 0) begin errors++; $display("FAIL stall_timeout got %0d exp done", cyc); end
        checks++; if (cap.size() !== 320) begin errors++; $display("FAIL stall_count got %0d exp 320", cap.size()); end
        fd = first_diff();
        checks++; if (fd !== -1) begin errors++; $display("FAIL stall_bytes byte %0d got %h exp %h", fd, cap[fd], expq[fd]); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", sb); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, sb, bad, guard, done_seen;
        for (int k = 0; k < 256; k++) mem[k] = 12'd1665;
        cap.delete();
        sel = 0; ready = 1'b1; guard = 0;
        @(negedge clk);
        en[0] = 1'b1;
        while (cap.size() < 10 && guard < 2000) begin
            @(negedge clk);
            en = '0;
            guard++;
            if (cv && ready) cap.push_back(cb);
        end
        checks++; if (cap.size() !== 10) begin errors++; $display("FAIL abort_reach got %0d bytes exp 10", cap.size()); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (b1.busy !== 1'b0 || b1.oByte_valid !== 1'b0 || b1.Function_done !== 1'b0)
            begin errors++; $display("FAIL abort_ctrl got busy=%b valid=%b done=%b exp 0 0 0", b1.busy, b1.oByte_valid, b1.Function_done); end
        checks++; if (b1.Coeff_RAd !== 8'd0 || b1.oByte !== 8'h00)
            begin errors++; $display("FAIL abort_data got addr=%0d byte=%h exp 0 00", b1.Coeff_RAd, b1.oByte); end
        done_seen = 0;
        repeat (3) begin @(negedge clk); if (b1.Function_done) done_seen++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (b1.Function_done) done_seen++; end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", done_seen); end

        // Fresh run with a stray enable pulse while busy
        run_dut(0, 1'b0, 200, 2000, cyc, sb);
        checks++; if (cyc !== 802) begin errors++; $display("FAIL rerun_len got %0d exp 802", cyc); end
        bad = 0;
        foreach (cap[i]) if (cap[i] !== 8'hFF) bad++;
        checks++; if (cap.size() !== 32 || bad !== 0) begin errors++; $display("FAIL rerun_bytes got %0d bytes %0d wrong exp 32 FF", cap.size(), bad); end
        repeat (3) @(negedge clk);
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL rerun_idle got busy=%b exp 0", b1.busy); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_d1_const();
        test_d1_alternating();
        test_d4();
        test_d10();
        test_back_to_back_stall();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_compress_pack.md
# poly_compress_pack

Parametrised coefficient compressor and byte packer for the Kyber512 decapsulation/encryption datapath. It generalises polynomial-to-message conversion from 1 bit per coefficient to COMP_D bits per coefficient. It reads KYBER_N coefficients serially from a synchronous coefficient RAM, applies Kyber Compress_q(x, COMP_D), and packs the results little-endian into a byte stream with valid/ready backpressure. One instance with COMP_D=1 replaces poly-to-msg; COMP_D=4/10 serve ciphertext v/u packing.

## Interface
- KYBER_N, 256, coefficients per polynomial (power of 2)
- KYBER_Q, 3329, modulus
- data_Width, 12, coefficient width
- COMP_D, 1, compressed bits per coefficient (1..11)
- ADDR_W, 8, log2(KYBER_N)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  start pulse; sampled only in IDLE
- Coeff_RData  in  data_Width  RAM read data, valid one cycle after Coeff_RAd changes
- Coeff_RAd  out  ADDR_W  RAM read address
- busy  out  1  high from start until Function_done
- oByte  out  8  packed output byte
- oByte_valid  out  1  oByte holds a valid byte
- oByte_ready  in  1  consumer accepts when valid&&ready at a rising edge
- Function_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- Compress: t = floor((x·2^COMP_D + floor(KYBER_Q/2)) / KYBER_Q) mod 2^COMP_D. Defined for every data_Width-bit x; bit-exact, any divider implementation that meets the Timing latency.
- Packing: coefficient k occupies stream bits [k·COMP_D, k·COMP_D+COMP_D-1]; stream bit b is bit (b mod 8) of byte floor(b/8). Total bytes = KYBER_N·COMP_D/8, exact (no partial tail byte for legal COMP_D with KYBER_N=256).
- Bit accumulator: ≥ 7+COMP_D bits plus a count; new t is ORed in above the current count; bytes are taken from the LSBs.
- FSM states:
  - IDLE: waits for enable.
  - READ: drives Coeff_RAd = k.
  - WAIT: lets the RAM deliver the read data.
  - COMP: registers t into the accumulator.
  - EMIT: outputs bytes while count ≥ 8.
  - DONE: raises Function_done.
- Transitions:
  - IDLE→READ on enable.
  - READ→WAIT.
  - WAIT→COMP.
  - COMP→EMIT if count+COMP_D ≥ 8, else READ (k+1), or DONE if k was KYBER_N-1 and count+COMP_D == 0 mod 8 with nothing pending.
  - EMIT stays while count ≥ 8. Once count < 8 after a handshake, EMIT→READ (k+1), or →DONE if k = KYBER_N-1.
  - DONE→IDLE after one cycle.
- enable while busy: ignored. enable held high: a new run starts on the cycle after DONE returns to IDLE.
- Reset values: Coeff_RAd=0, busy=0, oByte=0, oByte_valid=0, Function_done=0, accumulator/count=0, state IDLE.
- rst mid-run aborts immediately. No Function_done is produced; any partial byte is discarded.

## Timing
- Start: enable sampled high in IDLE at edge E0. READ during E0→E1 with Coeff_RAd=0, busy=1 from E0.
- Per coefficient without backpressure: 3 cycles (READ, WAIT, COMP), plus 1 cycle per byte emitted.
- oByte_valid asserts in the first EMIT cycle. oByte and oByte_valid must hold stable while valid && !ready.
- Each handshake advances one byte. Back-to-back bytes on consecutive cycles are required when ready stays high.
- Function_done: single-cycle pulse the cycle after the final handshake; busy drops in the same cycle.
- No-backpressure run length with COMP_D=1: 256·3 + 32 + 2 cycles from E0 to Function_done (bench checks ±0).

## Test plan
- COMP_D=1, all x=1665 → 32 bytes 0xFF, then one Function_done pulse. All x=0 → 32×0x00.
- COMP_D=1 boundaries:
  - x=832 → 0, x=833 → 1, x=2496 → 1, x=2497 → 0, x=3328 → 0.
  - Alternating 833/832 → every byte 0x55.
- COMP_D=4, all x=1665 → 128 bytes 0x88. Ramp x=k → byte j = Compress(2j) | Compress(2j+1)<<4, checked against the reference model.
- COMP_D=10, x=3328 → t=0 (wrap). Ramp x=13k → 320 bytes matching the model. Exercises 10-bit straddling of byte boundaries.
- Random oByte_ready (30% high): byte sequence identical to the no-stall run, oByte stable during stalls, no byte dropped or duplicated.
- rst asserted at byte 10 mid-run → all outputs at reset values next edge, no Function_done. A fresh enable then produces the full correct stream. An enable pulse during busy has no effect.
